// File: rtl/exe_mem_stage_if.sv
// Bundle of the ID/EXE-side inputs and EXE/MEM-side outputs of the execute stage.
// The master side drives the decoded instruction; the slave side is the execute stage itself.
interface exe_mem_if;
    logic        ewreg;
    logic        em2reg;
    logic        ewmem;
    logic [3:0]  ealuc;
    logic        ealuimm;
    logic [4:0]  edestReg;
    logic [31:0] eqa;
    logic [31:0] eqb;
    logic [31:0] eimm32;

    logic        stall;
    logic        mwreg;
    logic        mm2reg;
    logic        mwmem;
    logic [4:0]  mdestReg;
    logic [31:0] mr;
    logic [31:0] mqb;

    modport master (
        output ewreg, em2reg, ewmem, ealuc, ealuimm, edestReg, eqa, eqb, eimm32,
        input  stall, mwreg, mm2reg, mwmem, mdestReg, mr, mqb
    );

    modport slave (
        input  ewreg, em2reg, ewmem, ealuc, ealuimm, edestReg, eqa, eqb, eimm32,
        output stall, mwreg, mm2reg, mwmem, mdestReg, mr, mqb
    );
endinterface

// File: rtl/exe_mem_stage.sv
// MIPS execute stage with EXE/MEM register: single-cycle ALU plus an iterative
// 32-step multiply/divide that stalls upstream and bubbles MEM while it runs.
module exe_mem_stage (
    input  logic      clock,
    input  logic      resetn,
    exe_mem_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_AND  = 4'b0010;
    localparam logic [3:0] ALU_OR   = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SLT  = 4'b0101;
    localparam logic [3:0] ALU_SLL  = 4'b0110;
    localparam logic [3:0] ALU_SRL  = 4'b0111;
    localparam logic [3:0] ALU_SRA  = 4'b1000;
    localparam logic [3:0] ALU_LUI  = 4'b1001;
    localparam logic [3:0] ALU_MUL  = 4'b1010;
    localparam logic [3:0] ALU_DIVU = 4'b1011;

    state_e      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] hi_q, hi_d;      // mul: upper partial product; divu: remainder
    logic [31:0] lo_q, lo_d;      // mul: multiplier shifting out / product low; divu: quotient
    logic [31:0] opnd_q, opnd_d;  // mul: multiplicand; divu: divisor
    logic        div_q, div_d;

    logic        mwreg_q, mm2reg_q, mwmem_q;
    logic [4:0]  mdest_q;
    logic [31:0] mr_q, mqb_q;

    logic [31:0] op_b;
    logic [31:0] alu_r;
    logic [31:0] result;
    logic        is_multi;
    logic        stall;
    logic [32:0] mul_sum;
    logic [32:0] div_shift;

    assign op_b     = bus.ealuimm ? bus.eimm32 : bus.eqb;
    assign is_multi = (bus.ealuc == ALU_MUL) || (bus.ealuc == ALU_DIVU);

    // Held low in reset so the upstream stages are never frozen by a dead FSM.
    assign stall = resetn && (((state_q == IDLE) && is_multi) || (state_q == BUSY));

    always_comb begin
        alu_r = '0;
        case (bus.ealuc)
            ALU_ADD: alu_r = bus.eqa + op_b;
            ALU_SUB: alu_r = bus.eqa - op_b;
            ALU_AND: alu_r = bus.eqa & op_b;
            ALU_OR:  alu_r = bus.eqa | op_b;
            ALU_XOR: alu_r = bus.eqa ^ op_b;
            ALU_SLT: alu_r = {31'd0, $signed(bus.eqa) < $signed(op_b)};
            ALU_SLL: alu_r = op_b << bus.eqa[4:0];
            ALU_SRL: alu_r = op_b >> bus.eqa[4:0];
            ALU_SRA: alu_r = $unsigned($signed(op_b) >>> bus.eqa[4:0]);
            ALU_LUI: alu_r = {op_b[15:0], 16'd0};
            default: alu_r = '0;
        endcase
    end

    // Both iterative ops leave their answer in lo_q once DONE is reached.
    assign result = (state_q == DONE) ? lo_q : alu_r;

    always_comb begin
        // NOTE: every variable gets a default first so no path through the case infers a latch.
        state_d   = state_q;
        cnt_d     = cnt_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        opnd_d    = opnd_q;
        div_d     = div_q;
        mul_sum   = '0;
        div_shift = '0;
        case (state_q)
            IDLE: begin
                if (is_multi) begin
                    div_d   = (bus.ealuc == ALU_DIVU);
                    cnt_d   = 5'd31;
                    hi_d    = '0;
                    lo_d    = div_d ? bus.eqa : op_b;
                    opnd_d  = div_d ? op_b : bus.eqa;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (div_q) begin
                    // Restoring step; a zero divisor always "fits", giving all-ones.
                    div_shift = {hi_q, lo_q[31]};
                    if (div_shift >= {1'b0, opnd_q}) begin
                        hi_d = div_shift[31:0] - opnd_q;
                        lo_d = {lo_q[30:0], 1'b1};
                    end else begin
                        hi_d = div_shift[31:0];
                        lo_d = {lo_q[30:0], 1'b0};
                    end
                end else begin
                    mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : 33'd0);
                    hi_d    = mul_sum[32:1];
                    lo_d    = {mul_sum[0], lo_q[31:1]};
                end
                cnt_d = cnt_q - 5'd1;
                if (cnt_q == 5'd0) state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        // NOTE: partial registers are reset too, so an op aborted by reset leaves no trace.
        if (!resetn) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            opnd_q  <= '0;
            div_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking so every register samples the pre-edge values.
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            opnd_q  <= opnd_d;
            div_q   <= div_d;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            mwreg_q  <= 1'b0;
            mm2reg_q <= 1'b0;
            mwmem_q  <= 1'b0;
            mdest_q  <= '0;
            mr_q     <= '0;
            mqb_q    <= '0;
        end else if (stall) begin
            // Bubble: kill the side-effecting controls, keep the data fields.
            mwreg_q  <= 1'b0;
            mm2reg_q <= 1'b0;
            mwmem_q  <= 1'b0;
        end else begin
            mwreg_q  <= bus.ewreg;
            mm2reg_q <= bus.em2reg;
            mwmem_q  <= bus.ewmem;
            mdest_q  <= bus.edestReg;
            mr_q     <= result;
            mqb_q    <= bus.eqb;
        end
    end

    assign bus.stall    = stall;
    assign bus.mwreg    = mwreg_q;
    assign bus.mm2reg   = mm2reg_q;
    assign bus.mwmem    = mwmem_q;
    assign bus.mdestReg = mdest_q;
    assign bus.mr       = mr_q;
    assign bus.mqb      = mqb_q;
endmodule

// File: tb/tb_exe_mem_stage.sv
// Self-checking bench for exe_mem_stage: directed cases plus randomized ops
// compared against an arithmetic reference model of the ALU and mul/divu.
module tb_exe_mem_stage;
    logic clock;
    logic resetn;
    int   total;
    int   bad;

    exe_mem_if bus ();

    exe_mem_stage dut (
        .clock  (clock),
        .resetn (resetn),
        .bus    (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SLT  = 4'd5;
    localparam logic [3:0] OP_SRA  = 4'd8;
    localparam logic [3:0] OP_MUL  = 4'd10;
    localparam logic [3:0] OP_DIVU = 4'd11;

    // Reference model: plain arithmetic on the operands.
    function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        logic [63:0] prod;
        logic [63:0] sext;
        int          sa, sb;
        sa   = a;
        sb   = b;
        prod = 64'(a) * 64'(b);
        sext = {{32{b[31]}}, b};
        case (op)
            4'd0:    return a + b;
            4'd1:    return a - b;
            4'd2:    return a & b;
            4'd3:    return a | b;
            4'd4:    return a ^ b;
            4'd5:    return (sa < sb) ? 32'd1 : 32'd0;
            4'd6:    return b << a[4:0];
            4'd7:    return b >> a[4:0];
            4'd8:    return 32'(sext >> a[4:0]);
            4'd9:    return b * 32'd65536;
            4'd10:   return prod[31:0];
            4'd11:   return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [72:0] outs();
        return {bus.stall, bus.mwreg, bus.mm2reg, bus.mwmem, bus.mdestReg, bus.mr, bus.mqb};
    endfunction

    task automatic set_inputs(input logic [3:0] op, input logic imm_sel, input logic [31:0] a,
                              input logic [31:0] qb, input logic [31:0] imm, input logic [4:0] dest,
                              input logic wreg, input logic m2reg, input logic wmem);
        bus.ealuc    = op;
        bus.ealuimm  = imm_sel;
        bus.eqa      = a;
        bus.eqb      = qb;
        bus.eimm32   = imm;
        bus.edestReg = dest;
        bus.ewreg    = wreg;
        bus.em2reg   = m2reg;
        bus.ewmem    = wmem;
    endtask

    // Starts at a negedge, returns at the negedge one cycle later.
    task automatic run_single(input string name, input logic [3:0] op, input logic imm_sel,
                              input logic [31:0] a, input logic [31:0] qb, input logic [31:0] imm,
                              input logic [4:0] dest, input logic wreg, input logic m2reg,
                              input logic wmem);
        logic [72:0] exp_v;
        set_inputs(op, imm_sel, a, qb, imm, dest, wreg, m2reg, wmem);
        #1;
        total++;
        if (bus.stall !== 1'b0) begin
            bad++;
            $display("FAIL %s_stall: got %b want 0", name, bus.stall);
        end
        exp_v = {1'b0, wreg, m2reg, wmem, dest, ref_alu(op, a, imm_sel ? imm : qb), qb};
        @(negedge clock);
        total++;
        if (outs() !== exp_v) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, outs(), exp_v);
        end
    endtask

    // Starts at a negedge in cycle 0, returns at the negedge of cycle 34.
    task automatic run_multi(input string name, input logic [3:0] op, input logic [31:0] a,
                             input logic [31:0] b, input logic [4:0] dest, input logic wreg,
                             input logic m2reg, input logic wmem);
        int          stall_cycles;
        logic        bubble_bad;
        logic [72:0] exp_v;
        set_inputs(op, 1'b0, a, b, $urandom, dest, wreg, m2reg, wmem);
        #1;
        stall_cycles = 0;
        bubble_bad   = 1'b0;
        while (bus.stall === 1'b1 && stall_cycles < 40) begin
            stall_cycles++;
            @(negedge clock);
            if ({bus.mwreg, bus.mm2reg, bus.mwmem} !== 3'b000) bubble_bad = 1'b1;
        end
        total++;
        if (stall_cycles != 33) begin
            bad++;
            $display("FAIL %s_stall_len: got %0d cycles want 33", name, stall_cycles);
        end
        total++;
        if (bubble_bad) begin
            bad++;
            $display("FAIL %s_bubble: MEM controls got nonzero want 000 during stall", name);
        end
        exp_v = {1'b1, wreg, m2reg, wmem, dest, ref_alu(op, a, b), b};
        @(negedge clock);
        // Inputs still hold the same op, so IDLE must restart it in cycle 34.
        total++;
        if (outs() !== exp_v) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, outs(), exp_v);
        end
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        set_inputs(OP_MUL, 1'b0, 32'd3, 32'd4, 32'd0, 5'd1, 1'b1, 1'b1, 1'b1);
        repeat (2) @(negedge clock);
        total++;
        if (outs() !== 73'd0) begin
            bad++;
            $display("FAIL reset_state: got %h want 0", outs());
        end
        set_inputs(OP_ADD, 1'b0, 32'd0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        resetn = 1'b1;
        @(negedge clock);
    endtask

    task automatic test_directed_alu();
        run_single("add_wrap", OP_ADD, 1'b0, 32'h7FFF_FFFF, 32'd1, 32'd0, 5'd5, 1'b1, 1'b0, 1'b0);
        run_single("sw_addr", OP_ADD, 1'b1, 32'h100, 32'hDEAD_BEEF, 32'hFFFF_FFFC, 5'd9,
                   1'b0, 1'b0, 1'b1);
        run_single("slt_neg", OP_SLT, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'd0, 5'd3, 1'b1, 1'b0, 1'b0);
        run_single("sra", OP_SRA, 1'b0, 32'd4, 32'h8000_0000, 32'd0, 5'd4, 1'b1, 1'b0, 1'b0);
        run_single("op_1111", 4'b1111, 1'b0, 32'h1234, 32'h5678, 32'd0, 5'd6, 1'b1, 1'b1, 1'b0);
    endtask

    task automatic test_random_alu();
        logic [3:0] op;
        for (int i = 0; i < 40; i++) begin
            op = 4'($urandom_range(0, 13));
            if (op >= 4'd10) op = op + 4'd2;  // skip mul/divu, keep 1100-1111
            run_single("rand_alu", op, 1'($urandom), $urandom, $urandom, $urandom,
                       5'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
        end
    endtask

    task automatic test_multi();
        run_multi("mul", OP_MUL, 32'h0001_2345, 32'h0001_0000, 5'd7, 1'b1, 1'b0, 1'b0);
        run_multi("divu_100_7", OP_DIVU, 32'd100, 32'd7, 5'd8, 1'b1, 1'b0, 1'b0);
        run_multi("divu_by_0", OP_DIVU, 32'd5, 32'd0, 5'd9, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 4; i++) begin
            run_multi("b2b_rand", (i % 2 == 0) ? OP_MUL : OP_DIVU, $urandom,
                      (i == 3) ? 32'd0 : $urandom >> $urandom_range(0, 31),
                      5'($urandom), 1'b1, 1'($urandom), 1'b0);
        end
        run_single("after_multi", OP_ADD, 1'b0, 32'd10, 32'd20, 32'd0, 5'd2, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_reset_mid_divide();
        run_single("pre_abort", OP_ADD, 1'b0, 32'd1, 32'd2, 32'd0, 5'd12, 1'b1, 1'b1, 1'b1);
        set_inputs(OP_DIVU, 1'b0, 32'd1000, 32'd3, 32'd0, 5'd13, 1'b1, 1'b0, 1'b0);
        repeat (10) @(negedge clock);
        resetn = 1'b0;
        #1;
        total++;
        if (outs() !== 73'd0) begin
            bad++;
            $display("FAIL reset_mid_divu: got %h want 0", outs());
        end
        set_inputs(OP_ADD, 1'b0, 32'd40, 32'd2, 32'd0, 5'd14, 1'b1, 1'b0, 1'b0);
        @(negedge clock);
        resetn = 1'b1;
        run_single("post_abort_add", OP_ADD, 1'b0, 32'd40, 32'd2, 32'd0, 5'd14,
                   1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_directed_alu();
        test_random_alu();
        test_multi();
        test_back_to_back();
        test_reset_mid_divide();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/exe_mem_stage.md
# exe_mem_stage

Execute stage plus EXE/MEM pipeline register of the 5-stage MIPS core. It consumes the ID/EXE register outputs, computes the ALU result (single-cycle ops) or runs an iterative 32-bit multiply/divide (multi-cycle ops), and registers result, store data and control bits for the MEM stage. While a multi-cycle op runs it asserts `stall` to freeze the upstream stages, and it inserts bubbles into MEM.

## Interface
Parameters:
- none; datapath fixed at 32 bits, register index at 5 bits.

Ports:
- `clock` in 1: single clock, all state on rising edge.
- `resetn` in 1: asynchronous, active-low reset.
- `ewreg`, `em2reg`, `ewmem` in 1 each: register-write, mem-to-reg and mem-write controls from ID/EXE.
- `ealuc` in 4: ALU operation select.
- `ealuimm` in 1: 1 selects `eimm32` as operand B, 0 selects `eqb`.
- `edestReg` in 5: destination register index.
- `eqa`, `eqb`, `eimm32` in 32 each: operand A, register operand B / store data, sign-extended immediate.
- `stall` out 1: combinational; while high, upstream holds PC, IF/ID and ID/EXE unchanged.
- `mwreg`, `mm2reg`, `mwmem` out 1 each: registered controls to MEM.
- `mdestReg` out 5: registered destination index.
- `mr` out 32: registered ALU/mul/div result (memory address for loads/stores).
- `mqb` out 32: registered `eqb` (store data).

## Operation
- Operand B is `ealuimm ? eimm32 : eqb`; A is `eqa`.
- `ealuc` encoding: 0000 add, 0001 sub, 0010 and, 0011 or, 0100 xor, 0101 slt (signed, result 1/0), 0110 sll (B << A[4:0]), 0111 srl (B >> A[4:0], logical), 1000 sra (arithmetic), 1001 lui (B << 16), 1010 mul (unsigned, low 32 bits of product), 1011 divu (unsigned quotient). Codes 1100–1111 give result 0.
- add/sub wrap modulo 2^32. No overflow flag or trap.
- divu by zero gives quotient 0xFFFFFFFF. It completes in the normal number of cycles.
- FSM states: IDLE, BUSY, DONE.
  - IDLE: if `ealuc` is mul or divu, latch A/B, load iteration counter with 31, go to BUSY, and assert `stall`. Otherwise `stall`=0 and do a single-cycle capture.
  - BUSY: perform one shift-add (mul) or restoring-subtract (divu) step per cycle, with `stall`=1. Counter decrements; after the step with counter=0, go to DONE.
  - DONE: `stall`=0 and the final result drives the capture path. Next state is IDLE.
- EXE/MEM capture each rising edge:
  - When `stall`=1, insert a bubble: `mwreg`, `mm2reg`, `mwmem` are cleared, and `mdestReg`, `mr`, `mqb` hold their values.
  - When `stall`=0, all outputs load from the inputs and the result.
- Multi-cycle ops start only from IDLE. The instruction seen in DONE is never restarted, because upstream advances on the DONE edge.
- Reset (any time, including mid-divide): state goes to IDLE, the counter and partial registers are cleared, all outputs go to 0, and `stall`=0. The aborted op produces no MEM-side effect.

## Timing
- Single-cycle ops: inputs valid in cycle N; outputs valid after the rising edge ending cycle N. Latency is 1.
- Multi-cycle ops presented in cycle 0:
  - `stall` is high during cycles 0–32 (33 cycles).
  - DONE is in cycle 33.
  - The result is captured on the edge ending cycle 33. Latency is 34.
- Back-to-back mul: the second op enters IDLE in cycle 34 and raises `stall` in that same cycle.
- `stall` depends only on the state and `ealuc`. It never depends on the outputs.

## Test plan
- Reset, then add with A=0x7FFFFFFF, B=1, ewreg=1, dest=5 -> next edge: mr=0x80000000, mwreg=1, mdestReg=5, stall never high.
- sw with ealuimm=1, A=0x100, imm=0xFFFFFFFC, eqb=0xDEADBEEF, ewmem=1 -> mr=0x000000FC, mqb=0xDEADBEEF, mwmem=1.
- slt with A=0xFFFFFFFF, B=1 -> mr=1. sra with A=4, B=0x80000000 -> mr=0xF8000000. ealuc=1111 -> mr=0.
- mul with A=0x00012345, B=0x00010000 -> stall high for exactly 33 cycles, MEM controls 0 during the stall, then mr=0x23450000 with the original dest and controls. Next op issues in cycle 34.
- divu 100/7 -> mr=14 at latency 34. divu 5/0 -> mr=0xFFFFFFFF at latency 34.
- Assert resetn low in cycle 10 of a divu -> all outputs 0 and stall 0 at once. After release, an add completes in 1 cycle with no residual effect.
